// File: rtl/arbitro_interruptores.sv
// arbitro_interruptores
//   Round-robin arbiter that shares one 2-bit lamp command among N switch
//   requesters. The winner keeps the lamp for at least HOLD cycles and y
//   follows that winner's command slice. Master key m=0 overrides everything
//   and forces y to switch 0's command.
//
// Ports
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   m          in   1      master key; 0 = override, switch 0 drives y
//   int_cmd    in   2*N    packed switch commands; [2i+1:2i] = switch i
//   s          in   N      request vector; s[i]=1 means switch i requests
//   y          out  2      registered lamp command
//   grant      out  N      registered one-hot grant; zero when none
//   grant_idx  out  IW     registered index of granted switch; 0 when none
//
// state  | meaning
// IDLE   | no owner; arbitrate from ptr when any request is present
// ATIVO  | grant_idx owns the lamp; cnt counts down the remaining hold
// LIBERA | one-cycle fairness gap after handing the lamp back

module arbitro_interruptores #(
  parameter  int N    = 16,
  parameter  int HOLD = 4,
  localparam int IW   = $clog2(N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m,
  input  logic [2*N-1:0]    int_cmd,
  input  logic [N-1:0]      s,
  output logic [1:0]        y,
  output logic [N-1:0]      grant,
  output logic [IW-1:0]     grant_idx
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, ATIVO, LIBERA} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   idx_nx;
  logic [N-1:0]    grant_nx;
  logic [1:0]      y_nx;

  logic [IW-1:0]   w;
  logic            found;
  logic            held;
  logic            others;
  logic [IW-1:0]   ptr_inc;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    int cand;
    cand  = 0;
    found = 1'b0;
    w     = '0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && s[cand]) begin
        found = 1'b1;
        w     = cand[IW-1:0];
      end
    end
  end

  assign held    = s[grant_idx];
  assign others  = |(s & ~grant);
  assign ptr_inc = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      y         <= '0;
      grant     <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ptr       <= ptr_nx;
      y         <= y_nx;
      grant     <= grant_nx;
      grant_idx <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!m) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (found) state_nx = ATIVO;
        ATIVO: begin
          if (cnt == '0) begin
            if (!held)       state_nx = IDLE;
            else if (others) state_nx = LIBERA;
          end
        end
        LIBERA:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next registered outputs; the default is the "no owner" picture.
  always_comb begin
    y_nx     = int_cmd[1:0];
    grant_nx = '0;
    idx_nx   = '0;
    cnt_nx   = '0;
    ptr_nx   = ptr;
    if (m) begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_nx = {{(N-1){1'b0}}, 1'b1} << w;
            idx_nx   = w;
            y_nx     = int_cmd[{w, 1'b0} +: 2];
            cnt_nx   = CW'(HOLD - 1);
          end
        end
        ATIVO: begin
          if (cnt != '0) begin
            grant_nx = grant;
            idx_nx   = grant_idx;
            y_nx     = int_cmd[{grant_idx, 1'b0} +: 2];
            cnt_nx   = cnt - 1'b1;
          end else if (!held || others) begin
            ptr_nx = ptr_inc;
          end else begin
            // Sole requester keeps the lamp with no gap.
            grant_nx = grant;
            idx_nx   = grant_idx;
            y_nx     = int_cmd[{grant_idx, 1'b0} +: 2];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_interruptores.sv
module tb_arbitro_interruptores;

  logic        clock = 1'b0;
  logic        reset;
  logic        m;
  logic [31:0] int_cmd;
  logic [15:0] s;
  logic [1:0]  y;
  logic [15:0] grant;
  logic [3:0]  grant_idx;

  arbitro_interruptores #(.N(16), .HOLD(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .m         (m),
    .int_cmd   (int_cmd),
    .s         (s),
    .y         (y),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  y;
    logic [15:0] g;
    logic [3:0]  idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the edge.
  task automatic step(input logic r, input logic mm, input logic [15:0] ss,
                      input logic [31:0] ic, input logic [1:0] ey,
                      input logic [15:0] eg, input logic [3:0] ei);
    exp_t e;
    @(negedge clock);
    reset   = r;
    m       = mm;
    s       = ss;
    int_cmd = ic;
    e.y   = ey;
    e.g   = eg;
    e.idx = ei;
    sb.push_back(e);
    step_no++;
  endtask

  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("y", {30'd0, y}, {30'd0, mon_e.y});
      chk("grant", {16'd0, grant}, {16'd0, mon_e.g});
      chk("grant_idx", {28'd0, grant_idx}, {28'd0, mon_e.idx});
      chk("onehot0", {31'd0, $onehot0(grant)}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    m       = 1'b1;
    s       = '0;
    int_cmd = '1;

    // reset with all-ones commands, then idle follows switch 0
    step(1, 1, 16'h0000, 32'hFFFF_FFFF, 2'b00, 16'h0000, 4'd0);
    step(1, 1, 16'h0000, 32'hFFFF_FFFF, 2'b00, 16'h0000, 4'd0);
    step(0, 1, 16'h0000, 32'hFFFF_FFFF, 2'b11, 16'h0000, 4'd0);

    // single request, dropped after one cycle: grant lasts HOLD cycles
    step(0, 1, 16'h0004, 32'h0000_0021, 2'b10, 16'h0004, 4'd2);
    repeat (3) step(0, 1, 16'h0000, 32'h0000_0021, 2'b10, 16'h0004, 4'd2);
    step(0, 1, 16'h0000, 32'h0000_0021, 2'b01, 16'h0000, 4'd0);

    // two constant requesters alternate with a 2-cycle gap, ptr wraps 15->0
    step(1, 1, 16'h0000, 32'hC000_0001, 2'b00, 16'h0000, 4'd0);
    for (int r = 0; r < 2; r++) begin
      repeat (4) step(0, 1, 16'h8001, 32'hC000_0001, 2'b01, 16'h0001, 4'd0);
      repeat (2) step(0, 1, 16'h8001, 32'hC000_0001, 2'b01, 16'h0000, 4'd0);
      repeat (4) step(0, 1, 16'h8001, 32'hC000_0001, 2'b11, 16'h8000, 4'd15);
      repeat (2) step(0, 1, 16'h8001, 32'hC000_0001, 2'b01, 16'h0000, 4'd0);
    end

    // master key override mid-grant, then switch 5 re-granted
    repeat (2) step(0, 1, 16'h0020, 32'h0000_0801, 2'b10, 16'h0020, 4'd5);
    step(0, 0, 16'h0020, 32'h0000_0801, 2'b01, 16'h0000, 4'd0);
    repeat (4) step(0, 1, 16'h0020, 32'h0000_0801, 2'b10, 16'h0020, 4'd5);
    step(0, 1, 16'h0000, 32'h0000_0801, 2'b01, 16'h0000, 4'd0);

    // sole long requester keeps the lamp, y tracks its command change
    repeat (20) step(0, 1, 16'h0200, 32'h0004_0000, 2'b01, 16'h0200, 4'd9);
    repeat (3)  step(0, 1, 16'h0200, 32'h000C_0000, 2'b11, 16'h0200, 4'd9);

    // reset mid-grant with everyone requesting; switch 0 then 1 win
    step(1, 1, 16'hFFFF, 32'h000C_0002, 2'b00, 16'h0000, 4'd0);
    repeat (4) step(0, 1, 16'hFFFF, 32'h000C_0002, 2'b10, 16'h0001, 4'd0);
    repeat (2) step(0, 1, 16'hFFFF, 32'h000C_0002, 2'b10, 16'h0000, 4'd0);
    step(0, 1, 16'hFFFF, 32'h000C_0002, 2'b00, 16'h0002, 4'd1);

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
